// File: rtl/egg_timer_ctrl.sv
// Egg timer control FSM: turns the start/cancel buttons and the 1 s tick into
// load/count_enable strobes for the digit counter chain, and times the alarm.
module egg_timer_ctrl #(
   parameter int ALARM_SECONDS = 10,
   parameter int ALARM_WIDTH   = 4
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       start_btn,
   input  logic       cancel_btn,
   input  logic       pulse_1s,
   input  logic       all_zero,
   output logic       load,
   output logic       count_enable,
   output logic       running,
   output logic       alarm,
   output logic [2:0] state
);

   typedef enum logic [2:0] {
      IDLE  = 3'd0,
      LOAD  = 3'd1,
      RUN   = 3'd2,
      PAUSE = 3'd3,
      ALARM = 3'd4
   } state_e;

   localparam logic [ALARM_WIDTH-1:0] TICK_LAST = ALARM_WIDTH'(ALARM_SECONDS - 1);

   state_e                 state_q, state_d;
   logic [ALARM_WIDTH-1:0] tick_q, tick_d;
   logic                   start_prev_q, cancel_prev_q;
   logic                   load_q, running_q, alarm_q;
   logic                   start_edge, cancel_edge;

   // Rising-edge detect on both buttons; the previous levels come out of reset
   // high so a button already held when reset releases is not seen as a press.
   always_comb begin
      start_edge  = start_btn & ~start_prev_q;
      cancel_edge = cancel_btn & ~cancel_prev_q;
   end

   // Next-state and alarm tick logic; cancel always beats start when both rise.
   always_comb begin
      state_d = state_q;
      tick_d  = tick_q;
      case (state_q)
         IDLE: begin
            if (start_edge && !cancel_edge) state_d = LOAD;
         end
         LOAD: begin
            state_d = RUN;
         end
         RUN: begin
            if (cancel_edge) begin
               state_d = IDLE;
            end else if (all_zero) begin
               state_d = ALARM;
               tick_d  = '0;
            end else if (start_edge) begin
               state_d = PAUSE;
            end
         end
         PAUSE: begin
            if (cancel_edge)     state_d = IDLE;
            else if (start_edge) state_d = RUN;
         end
         ALARM: begin
            if (start_edge || cancel_edge) begin
               state_d = IDLE;
            end else if (pulse_1s) begin
               if (tick_q == TICK_LAST) state_d = IDLE;
               else                     tick_d  = tick_q + ALARM_WIDTH'(1);
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   // State, tick counter, button history and registered status decodes.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q       <= IDLE;
         tick_q        <= '0;
         start_prev_q  <= 1'b1;
         cancel_prev_q <= 1'b1;
         load_q        <= 1'b0;
         running_q     <= 1'b0;
         alarm_q       <= 1'b0;
      end else begin
         state_q       <= state_d;
         tick_q        <= tick_d;
         start_prev_q  <= start_btn;
         cancel_prev_q <= cancel_btn;
         load_q        <= (state_d == LOAD);
         running_q     <= (state_d == RUN);
         alarm_q       <= (state_d == ALARM);
      end
   end

   // Output drive; count_enable stays combinational so the digit counters see
   // the tick in the same cycle it arrives.
   always_comb begin
      load         = load_q;
      running      = running_q;
      alarm        = alarm_q;
      state        = state_q;
      count_enable = pulse_1s & (state_q == RUN) & ~all_zero;
   end

endmodule
